// File: rtl/rand_pos_gen_pkg.sv
// Shared constants and the LFSR step function for the random position generator.
package rand_pos_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/rand_pos_gen_if.sv
// Bundle of the seed controls and generator outputs; the generator owns the slave side.
interface rand_pos_gen_if #(
  parameter int DIV_WIDTH = 32,
  parameter int BIN_WIDTH = 4
);
  import rand_pos_pkg::*;

  localparam int POS_WIDTH = 2 ** BIN_WIDTH;

  logic                  reseed;
  logic [LFSR_WIDTH-1:0] seed_val;
  logic [DIV_WIDTH-1:0]  div_out;
  logic [DIV_WIDTH-1:0]  div_rise;
  logic [LFSR_WIDTH-1:0] rand_out;
  logic [POS_WIDTH-1:0]  pos;

  modport master (
    output reseed, seed_val,
    input  div_out, div_rise, rand_out, pos
  );

  modport slave (
    input  reseed, seed_val,
    output div_out, div_rise, rand_out, pos
  );

endinterface

// File: rtl/rand_pos_gen_onehot_decode.sv
// Binary to one-hot decoder; purely combinational so it adds no latency.
module onehot_decode #(
  parameter int BIN_WIDTH = 4,
  localparam int POS_WIDTH = 2 ** BIN_WIDTH
) (
  input  logic [BIN_WIDTH-1:0] bin,
  output logic [POS_WIDTH-1:0] pos
);

  always_comb begin
    pos      = '0;
    pos[bin] = 1'b1;
  end

endmodule

// File: rtl/rand_pos_gen.sv
// Free-running divider with rising-edge strobes, a 16-bit Galois LFSR, and a
// one-hot decode of the LFSR low bits, all in one clock domain.
module rand_pos_gen
  import rand_pos_pkg::*;
#(
  parameter int DIV_WIDTH = 32,
  parameter int BIN_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rand_pos_gen_if.slave bus
);

  localparam int POS_WIDTH = 2 ** BIN_WIDTH;

  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [DIV_WIDTH-1:0]  div_prev;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [POS_WIDTH-1:0]  pos_dec;

  // Keeping the previous count lets the strobe come straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_prev <= '0;
    end else begin
      div_prev <= div_cnt;
      div_cnt  <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_DEFAULT_SEED;
    end else if (bus.reseed) begin
      lfsr <= (bus.seed_val == '0) ? LFSR_DEFAULT_SEED : bus.seed_val;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  onehot_decode #(
    .BIN_WIDTH (BIN_WIDTH)
  ) u_decode (
    .bin (lfsr[BIN_WIDTH-1:0]),
    .pos (pos_dec)
  );

  assign bus.div_out  = div_cnt;
  assign bus.div_rise = div_cnt & ~div_prev;
  assign bus.rand_out = lfsr;
  assign bus.pos      = pos_dec;

endmodule

// File: tb/tb_rand_pos_gen.sv
// Scoreboard bench for rand_pos_gen: a default build and a DIV_WIDTH=4/BIN_WIDTH=2 build.
module tb_rand_pos_gen;
  import rand_pos_pkg::*;

  typedef struct {
    logic [31:0] div_out;
    logic [31:0] div_rise;
    logic [15:0] rand_out;
    logic [15:0] pos;
    logic [3:0]  s_div;
    logic [3:0]  s_rise;
    logic [15:0] s_rand;
    logic [3:0]  s_pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb_q[$];
  exp_t e;

  logic [31:0] m_div, m_prev;
  logic [15:0] m_rand;
  logic [3:0]  ms_div, ms_prev;
  logic [15:0] ms_rand;

  always #5 clk = ~clk;

  rand_pos_gen_if #(.DIV_WIDTH(32), .BIN_WIDTH(4)) bus ();
  rand_pos_gen_if #(.DIV_WIDTH(4),  .BIN_WIDTH(2)) sbus ();

  rand_pos_gen #(.DIV_WIDTH(32), .BIN_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rand_pos_gen #(.DIV_WIDTH(4), .BIN_WIDTH(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Drive one cycle of stimulus, advance the reference model, queue the expectation.
  task automatic drive_cycle(input logic r, input logic rs, input logic [15:0] sv);
    exp_t x;
    @(negedge clk);
    rst          = r;
    bus.reseed   = rs;
    bus.seed_val = sv;
    if (r) begin
      m_div = '0; m_prev = '0; m_rand = 16'hACE1;
      ms_div = '0; ms_prev = '0; ms_rand = 16'hACE1;
    end else begin
      m_prev  = m_div;
      m_div   = m_div + 32'd1;
      m_rand  = rs ? ((sv == 16'h0) ? 16'hACE1 : sv) : ref_lfsr(m_rand);
      ms_prev = ms_div;
      ms_div  = ms_div + 4'd1;
      ms_rand = ref_lfsr(ms_rand);
    end
    x.div_out  = m_div;
    x.div_rise = m_div & ~m_prev;
    x.rand_out = m_rand;
    x.pos      = 16'd1 << m_rand[3:0];
    x.s_div    = ms_div;
    x.s_rise   = ms_div & ~ms_prev;
    x.s_rand   = ms_rand;
    x.s_pos    = 4'd1 << ms_rand[1:0];
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b0, 16'h0);
    drive_cycle(1'b1, 1'b0, 16'h0);
    void'(sb_q.pop_front());
    e = sb_q.pop_front();
    n_tests++;
    if (bus.rand_out !== 16'hACE1) begin
      n_fail++; $display("[TB] FAIL reset_rand: got %h expected %h", bus.rand_out, 16'hACE1);
    end
    n_tests++;
    if (bus.pos !== 16'h0002) begin
      n_fail++; $display("[TB] FAIL reset_pos: got %h expected %h", bus.pos, 16'h0002);
    end
    n_tests++;
    if (bus.div_out !== e.div_out || bus.div_rise !== e.div_rise) begin
      n_fail++; $display("[TB] FAIL reset_div: got %h/%h expected %h/%h",
                         bus.div_out, bus.div_rise, e.div_out, e.div_rise);
    end
    n_tests++;
    if (sbus.div_out !== e.s_div || sbus.pos !== e.s_pos || sbus.rand_out !== e.s_rand) begin
      n_fail++; $display("[TB] FAIL reset_small: got %h/%h/%h expected %h/%h/%h",
                         sbus.div_out, sbus.pos, sbus.rand_out, e.s_div, e.s_pos, e.s_rand);
    end
  endtask

  task automatic test_lfsr_sequence();
    logic [15:0] lit_rand [3];
    logic [15:0] lit_pos  [3];
    lit_rand = '{16'hE270, 16'h7138, 16'h389C};
    lit_pos  = '{16'h0001, 16'h0100, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0);
      e = sb_q.pop_front();
      n_tests++;
      if (bus.rand_out !== lit_rand[i] || bus.rand_out !== e.rand_out) begin
        n_fail++; $display("[TB] FAIL lfsr_seq[%0d]: got %h expected %h", i, bus.rand_out, lit_rand[i]);
      end
      n_tests++;
      if (bus.pos !== lit_pos[i]) begin
        n_fail++; $display("[TB] FAIL pos_seq[%0d]: got %h expected %h", i, bus.pos, lit_pos[i]);
      end
    end
  endtask

  task automatic test_divider_strobes();
    int bit3_hits  = 0;
    int small_wrap = 0;
    for (int i = 0; i < 45; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0);
      e = sb_q.pop_front();
      n_tests++;
      if (bus.div_out !== e.div_out || bus.div_rise !== e.div_rise) begin
        n_fail++; $display("[TB] FAIL div_main: got %h/%h expected %h/%h",
                           bus.div_out, bus.div_rise, e.div_out, e.div_rise);
      end
      n_tests++;
      if (bus.div_rise !== (bus.div_out & (~bus.div_out + 32'd1))) begin
        n_fail++; $display("[TB] FAIL div_lowbit: got %h expected %h at div %0d",
                           bus.div_rise, bus.div_out & (~bus.div_out + 32'd1), bus.div_out);
      end
      if (bus.div_rise[3]) begin
        bit3_hits++;
        n_tests++;
        if (bus.div_out !== 32'd8 && bus.div_out !== 32'd24 && bus.div_out !== 32'd40) begin
          n_fail++; $display("[TB] FAIL div_bit3_pos: got div %0d expected 8/24/40", bus.div_out);
        end
      end
      n_tests++;
      if (sbus.div_out !== e.s_div || sbus.div_rise !== e.s_rise) begin
        n_fail++; $display("[TB] FAIL div_small: got %h/%h expected %h/%h",
                           sbus.div_out, sbus.div_rise, e.s_div, e.s_rise);
      end
      if (e.s_div == 4'h0) begin
        small_wrap++;
        n_tests++;
        if (sbus.div_rise !== 4'h0) begin
          n_fail++; $display("[TB] FAIL small_wrap_rise: got %h expected 0", sbus.div_rise);
        end
      end
      if (e.s_div == 4'h1 && small_wrap > 0) begin
        n_tests++;
        if (sbus.div_rise !== 4'h1) begin
          n_fail++; $display("[TB] FAIL small_after_wrap: got %h expected 1", sbus.div_rise);
        end
      end
    end
    n_tests++;
    if (bit3_hits != 3 || small_wrap < 2) begin
      n_fail++; $display("[TB] FAIL div_counts: got %0d bit3 strobes, %0d wraps expected 3, >=2",
                         bit3_hits, small_wrap);
    end
  endtask

  task automatic test_reset_priority();
    drive_cycle(1'b1, 1'b1, 16'h1234);
    e = sb_q.pop_front();
    n_tests++;
    if (bus.rand_out !== 16'hACE1 || bus.rand_out !== e.rand_out) begin
      n_fail++; $display("[TB] FAIL rst_over_reseed: got %h expected %h", bus.rand_out, 16'hACE1);
    end
    n_tests++;
    if (bus.div_out !== 32'h0 || bus.div_rise !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_mid_div: got %h/%h expected 0/0", bus.div_out, bus.div_rise);
    end
  endtask

  task automatic test_reseed();
    drive_cycle(1'b0, 1'b1, 16'h0000);
    e = sb_q.pop_front();
    n_tests++;
    if (bus.rand_out !== 16'hACE1) begin
      n_fail++; $display("[TB] FAIL reseed_zero: got %h expected %h", bus.rand_out, 16'hACE1);
    end
    drive_cycle(1'b0, 1'b1, 16'h00F3);
    e = sb_q.pop_front();
    n_tests++;
    if (bus.rand_out !== 16'h00F3 || bus.pos !== 16'h0008) begin
      n_fail++; $display("[TB] FAIL reseed_f3: got %h/%h expected %h/%h",
                         bus.rand_out, bus.pos, 16'h00F3, 16'h0008);
    end
    drive_cycle(1'b0, 1'b0, 16'h0000);
    e = sb_q.pop_front();
    n_tests++;
    if (bus.rand_out !== 16'hB479 || bus.pos !== 16'h0200 || bus.rand_out !== e.rand_out) begin
      n_fail++; $display("[TB] FAIL reseed_resume: got %h/%h expected %h/%h",
                         bus.rand_out, bus.pos, 16'hB479, 16'h0200);
    end
  endtask

  task automatic test_free_run();
    int early_repeat = 0;
    drive_cycle(1'b1, 1'b0, 16'h0);
    void'(sb_q.pop_front());
    for (int i = 1; i <= 65535; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0);
      e = sb_q.pop_front();
      n_tests++;
      if (bus.rand_out !== e.rand_out || bus.rand_out === 16'h0 || !$onehot(bus.pos)
          || bus.pos !== e.pos) begin
        n_fail++; $display("[TB] FAIL free_run[%0d]: got %h/%h expected %h/%h",
                           i, bus.rand_out, bus.pos, e.rand_out, e.pos);
      end
      n_tests++;
      if (sbus.pos !== (4'd1 << sbus.rand_out[1:0]) || !$onehot(sbus.pos) || sbus.pos !== e.s_pos) begin
        n_fail++; $display("[TB] FAIL small_pos[%0d]: got %h expected %h", i, sbus.pos, e.s_pos);
      end
      if (i < 65535 && bus.rand_out === 16'hACE1) early_repeat++;
    end
    n_tests++;
    if (bus.rand_out !== 16'hACE1 || early_repeat != 0) begin
      n_fail++; $display("[TB] FAIL lfsr_period: got %h with %0d early repeats expected %h with 0",
                         bus.rand_out, early_repeat, 16'hACE1);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.reseed    = 1'b0;
    bus.seed_val  = 16'h0;
    sbus.reseed   = 1'b0;
    sbus.seed_val = 16'h0;
    test_reset();
    test_lfsr_sequence();
    test_divider_strobes();
    test_reset_priority();
    test_reseed();
    test_free_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_pos_gen.md
Name: rand_pos_gen

Overview:
- Stimulus/utility block combining three functions:
  - a free-running binary clock-divider counter with per-bit rising-edge strobes;
  - a 16-bit Galois LFSR pseudo-random generator;
  - a binary-to-one-hot position decoder driven by the LFSR's low bits.
- Used in benches and test fabrics to produce random one-hot selects and divided-clock enables from a single clock domain.

Parameters:
- DIV_WIDTH, 32, width of the divider counter and of the edge-strobe vector.
- BIN_WIDTH, 4, number of LFSR low bits decoded; POS_WIDTH = 2**BIN_WIDTH (derived localparam, 16 by default). Legal range 1..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- reseed  in  1  when high (and rst low), load LFSR from seed_val on next edge.
- seed_val  in  16  reseed value.
- div_out  out  DIV_WIDTH  divider counter value; bit k has period 2^(k+1) clk cycles.
- div_rise  out  DIV_WIDTH  bit k high for exactly one cycle when div_out[k] goes 0->1.
- rand_out  out  16  current LFSR state.
- pos  out  POS_WIDTH  one-hot decode of rand_out[BIN_WIDTH-1:0].

Behaviour:
- Reset (rst=1 at clk edge):
  - div_out <= 0; internal delayed copy div_prev <= 0, so div_rise = 0;
  - rand_out <= 16'hACE1; pos therefore 16'h0002.
  - rst overrides reseed.
- Divider:
  - div_out <= div_out + 1 every non-reset cycle.
  - Wraps from all-ones to 0; wrap produces only falling edges, no strobes.
- Edge strobes:
  - div_prev <= div_out each non-reset cycle; div_rise = div_out & ~div_prev (combinational from registers).
  - Strobe on bit k fires in the cycle where div_out[k:0] == 2^k.
  - First strobe after reset is div_rise[0] when div_out becomes 1.
- LFSR:
  - Galois, right-shift, taps 16'hB400 (x^16+x^14+x^13+x^11+1), maximal length 65535.
  - next = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000), every non-reset, non-reseed cycle.
- Reseed:
  - reseed=1 loads seed_val; if seed_val == 0, loads 16'hACE1 instead (the all-zero lock-up state is never entered).
  - Reseed takes effect on the edge; stepping resumes the following cycle.
- Decoder:
  - pos = 1 << rand_out[BIN_WIDTH-1:0]; purely combinational, zero latency from rand_out.
  - Exactly one bit of pos is set at all times after the first reset.
- Before the first reset, outputs are undefined; no X-masking is required.

Decomposition:
- Package rand_pos_pkg: LFSR_TAPS = 16'hB400, LFSR_DEFAULT_SEED = 16'hACE1, LFSR_WIDTH = 16.
- Sub-module onehot_decode (parameter BIN_WIDTH; in bin, out pos): purely combinational, reusable elsewhere.
- Divider, edge detect and LFSR stay inline in rand_pos_gen.

Test Plan:
- Reset then run 4 cycles, reseed=0 -> rand_out sequence ACE1, E270, 7138, 389C; pos sequence 0002, 0001, 0100, 1000.
- Assert rst mid-run (with reseed=1, seed_val=1234 simultaneously) -> next cycle rand_out=ACE1, div_out=0, div_rise=0 (reset wins).
- reseed=1, seed_val=16'h0000 -> rand_out=ACE1; seed_val=16'h00F3 -> rand_out=00F3, pos=16'h0008.
- After reset, count cycles -> div_rise[0] at div_out=1,3,5…; div_rise[3] only at div_out=8, 24, 40; each strobe exactly one cycle wide.
- DIV_WIDTH=4, run 20 cycles -> div_out wraps F->0 with div_rise=0 on that cycle; div_rise[0] at the following 1.
- Free-run 65535 cycles from reset -> rand_out returns to ACE1, never 0; pos always one-hot (onehot check every cycle); BIN_WIDTH=2 build -> pos 4 bits, equals 1<<rand_out[1:0].
